forward_arbiter: RTL and testbench

FORWARD_ARBITER -- requirements
Module: forward_arbiter

---
 rtl/forward_arbiter_pkg.sv | 15 +
 rtl/forward_arbiter_rr_pick.sv | 34 +++
 rtl/forward_arbiter.sv | 123 ++++++++++++
 tb/tb_forward_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/forward_arbiter_pkg.sv
// Shared types and helpers for the forward arbiter: FSM state encoding and
// the width of the requester tag.
package forward_arbiter_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } arbState_e;

  // A tag always needs at least one bit, even for two requesters.
  function automatic int tagWidth(input int numReq);
    return (numReq <= 2) ? 1 : $clog2(numReq);
  endfunction

endpackage

// File: rtl/forward_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first requester at or after
// lastGrant_i+1 (wrapping) whose request bit is set.
module rr_pick
  import forward_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]           reqVec_i,
  input  logic [tagWidth(NUM_REQ)-1:0] lastGrant_i,
  output logic                         found_o,
  output logic [tagWidth(NUM_REQ)-1:0] index_o
);

  localparam int TW = tagWidth(NUM_REQ);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;

  // Rotate so bit 0 is the requester after the last grant, then take the
  // lowest set bit; scanning downwards lets the lowest offset win.
  always_comb begin
    doubled = {reqVec_i, reqVec_i} >> (int'(lastGrant_i) + 1);
    rotated = doubled[NUM_REQ-1:0];
    found_o = 1'b0;
    index_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found_o = 1'b1;
        index_o = TW'((int'(lastGrant_i) + 1 + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/forward_arbiter.sv
// Round-robin arbiter that forwards one requester word at a time over a
// toggle-handshake channel, with a WAIT_ACK timeout counter.
module forward_arbiter
  import forward_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                          sysClk,
  input  logic                          sysReset,
  input  logic [NUM_REQ-1:0]            reqValid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
  output logic [NUM_REQ-1:0]            reqAck,
  output logic                          chanToggle,
  output logic [DATA_WIDTH-1:0]         chanData,
  output logic [tagWidth(NUM_REQ)-1:0]  chanTag,
  input  logic                          chanAckToggle,
  output logic                          busy,
  output logic [15:0]                   timeoutCount
);

  localparam int TW      = tagWidth(NUM_REQ);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES);

  arbState_e              state_q, state_d;
  logic [TW-1:0]          lastGrant_q, lastGrant_d;
  logic                   chanToggle_q, chanToggle_d;
  logic [DATA_WIDTH-1:0]  chanData_q, chanData_d;
  logic [TW-1:0]          chanTag_q, chanTag_d;
  logic [NUM_REQ-1:0]     reqAck_q, reqAck_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic [15:0]            timeoutCount_q, timeoutCount_d;

  logic                   pickFound;
  logic [TW-1:0]          pickIndex;
  logic [DATA_WIDTH-1:0]  reqWord [NUM_REQ];
  logic                   chanFree;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rrPick (
    .reqVec_i    (reqValid),
    .lastGrant_i (lastGrant_q),
    .found_o     (pickFound),
    .index_o     (pickIndex)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      reqWord[i] = reqData[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign chanFree = (chanToggle_q == chanAckToggle);

  always_comb begin
    state_d        = state_q;
    lastGrant_d    = lastGrant_q;
    chanToggle_d   = chanToggle_q;
    chanData_d     = chanData_q;
    chanTag_d      = chanTag_q;
    reqAck_d       = '0;
    timer_d        = timer_q;
    timeoutCount_d = timeoutCount_q;
    case (state_q)
      IDLE: begin
        if (chanFree && pickFound) begin
          state_d      = WAIT_ACK;
          lastGrant_d  = pickIndex;
          chanToggle_d = ~chanToggle_q;
          chanData_d   = reqWord[pickIndex];
          chanTag_d    = pickIndex;
          reqAck_d     = NUM_REQ'(1) << pickIndex;
          timer_d      = '0;
        end
      end
      WAIT_ACK: begin
        // An ack wins over a timeout landing on the same edge.
        if (chanAckToggle == chanToggle_q) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          if (timeoutCount_q != 16'hFFFF) begin
            timeoutCount_d = timeoutCount_q + 16'd1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state_q        <= IDLE;
      lastGrant_q    <= TW'(NUM_REQ - 1);
      chanToggle_q   <= 1'b0;
      chanData_q     <= '0;
      chanTag_q      <= '0;
      reqAck_q       <= '0;
      timer_q        <= '0;
      timeoutCount_q <= '0;
    end else begin
      state_q        <= state_d;
      lastGrant_q    <= lastGrant_d;
      chanToggle_q   <= chanToggle_d;
      chanData_q     <= chanData_d;
      chanTag_q      <= chanTag_d;
      reqAck_q       <= reqAck_d;
      timer_q        <= timer_d;
      timeoutCount_q <= timeoutCount_d;
    end
  end

  assign reqAck       = reqAck_q;
  assign chanToggle   = chanToggle_q;
  assign chanData     = chanData_q;
  assign chanTag      = chanTag_q;
  assign busy         = (state_q == WAIT_ACK);
  assign timeoutCount = timeoutCount_q;

endmodule

// File: tb/tb_forward_arbiter.sv
// Self-checking bench for forward_arbiter: a transaction-level reference
// model compared every cycle, plus directed scenarios with literal checks.
module tb_forward_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int TMO  = 15;

  logic              sysClk = 1'b0;
  logic              sysReset;
  logic [NREQ-1:0]   reqValid;
  logic [NREQ*DW-1:0] reqData;
  logic [NREQ-1:0]   reqAck;
  logic              chanToggle;
  logic [DW-1:0]     chanData;
  logic [1:0]        chanTag;
  logic              chanAckToggle;
  logic              busy;
  logic [15:0]       timeoutCount;

  always #5 sysClk = ~sysClk;

  forward_arbiter #(
    .NUM_REQ        (NREQ),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .sysClk        (sysClk),
    .sysReset      (sysReset),
    .reqValid      (reqValid),
    .reqData       (reqData),
    .reqAck        (reqAck),
    .chanToggle    (chanToggle),
    .chanData      (chanData),
    .chanTag       (chanTag),
    .chanAckToggle (chanAckToggle),
    .busy          (busy),
    .timeoutCount  (timeoutCount)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: one outstanding transfer at a time; a transfer that
  // has waited TMO+1 cycles without an ack logs a timeout and waits again.
  bit           mReady = 0;
  bit           mInFlight;
  bit           mToggle;
  logic [DW-1:0] mData;
  int           mTag;
  int           mLast;
  logic [NREQ-1:0] mAck;
  int           mWaited;
  int           mTimeouts;

  task automatic modelStep();
    int  g;
    bit  hit;
    mAck = '0;
    if (sysReset) begin
      mReady = 1; mInFlight = 0; mToggle = 0; mData = '0; mTag = 0;
      mLast = NREQ - 1; mWaited = 0; mTimeouts = 0;
      return;
    end
    if (!mInFlight) begin
      hit = 0; g = 0;
      for (int k = 1; k <= NREQ; k++) begin
        if (!hit && reqValid[(mLast + k) % NREQ]) begin
          hit = 1;
          g = (mLast + k) % NREQ;
        end
      end
      if (hit && (mToggle == chanAckToggle)) begin
        mData = reqData[g*DW +: DW];
        mTag = g; mLast = g; mToggle = ~mToggle;
        mAck[g] = 1'b1; mInFlight = 1; mWaited = 0;
      end
    end else if (chanAckToggle == mToggle) begin
      mInFlight = 0;
    end else begin
      mWaited++;
      if (mWaited == TMO + 1) begin
        mWaited = 0;
        if (mTimeouts < 65535) mTimeouts++;
      end
    end
  endtask

  always @(posedge sysClk) modelStep();

  always @(negedge sysClk) begin
    if (mReady) begin
      checkOutput("reqAck", reqAck, mAck);
      checkOutput("chanToggle", chanToggle, mToggle);
      checkOutput("chanData", chanData, mData);
      checkOutput("chanTag", chanTag, mTag);
      checkOutput("busy", busy, mInFlight);
      checkOutput("timeoutCount", timeoutCount, mTimeouts);
      checkOutput("ackOneHot", $countones(reqAck) <= 1, 1);
    end
  end

  bit countAcks = 0;
  int ackCnt [NREQ];
  always @(negedge sysClk) begin
    if (countAcks) begin
      for (int i = 0; i < NREQ; i++) ackCnt[i] += int'(reqAck[i]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sysClk);
  endtask

  task automatic applyStimulus(input logic rst, input logic [NREQ-1:0] valid,
                               input logic ack);
    sysReset      = rst;
    reqValid      = valid;
    chanAckToggle = ack;
  endtask

  task automatic setWord(input int idx, input logic [DW-1:0] value);
    reqData[idx*DW +: DW] = value;
  endtask

  int tags [5];
  int expTags [5] = '{0, 1, 2, 3, 0};
  int expAcks [NREQ] = '{2, 1, 1, 1};

  initial begin
    reqData = '0;
    applyStimulus(1'b1, '0, 1'b0);
    tick(2);
    $display("[TB] reset state");
    checkOutput("rst_toggle", chanToggle, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_count", timeoutCount, 0);
    checkOutput("rst_data", chanData, 0);

    $display("[TB] single requester");
    setWord(1, 32'hDEADBEEF);
    applyStimulus(1'b0, 4'b0010, 1'b0);
    tick(1);
    checkOutput("single_toggle", chanToggle, 1);
    checkOutput("single_data", chanData, 32'hDEADBEEF);
    checkOutput("single_tag", chanTag, 1);
    checkOutput("single_ack", reqAck, 4'b0010);
    reqValid = '0;
    tick(1);
    checkOutput("single_ackPulse", reqAck, 4'b0000);
    chanAckToggle = 1'b1;
    tick(1);
    checkOutput("single_idle", busy, 0);

    $display("[TB] round robin");
    applyStimulus(1'b1, '0, 1'b0);
    tick(1);
    for (int i = 0; i < NREQ; i++) begin
      setWord(i, 32'hA0000000 + i);
      ackCnt[i] = 0;
    end
    countAcks = 1;
    applyStimulus(1'b0, 4'b1111, 1'b0);
    for (int r = 0; r < 5; r++) begin
      int budget = 0;
      while (chanToggle === chanAckToggle && budget < 20) begin
        tick(1);
        budget++;
      end
      checkOutput("rr_grantSeen", budget < 20, 1);
      tags[r] = int'(chanTag);
      if (r == 4) reqValid = '0;
      tick(3);
      chanAckToggle = chanToggle;
    end
    tick(2);
    countAcks = 0;
    for (int r = 0; r < 5; r++) checkOutput($sformatf("rr_tag%0d", r), tags[r], expTags[r]);
    for (int i = 0; i < NREQ; i++) checkOutput($sformatf("rr_acks%0d", i), ackCnt[i], expAcks[i]);

    $display("[TB] timeout and capture hold");
    setWord(2, 32'hCAFE0002);
    reqValid = 4'b0100;
    tick(1);
    checkOutput("tmo_tag", chanTag, 2);
    checkOutput("tmo_busy", busy, 1);
    setWord(2, 32'h11111111);
    reqValid = '0;
    tick(1);
    checkOutput("hold_data", chanData, 32'hCAFE0002);
    tick(14);
    checkOutput("tmo_count15", timeoutCount, 0);
    tick(1);
    checkOutput("tmo_count16", timeoutCount, 1);
    tick(16);
    checkOutput("tmo_count32", timeoutCount, 2);
    checkOutput("tmo_dataHeld", chanData, 32'hCAFE0002);
    checkOutput("tmo_busyHeld", busy, 1);
    chanAckToggle = chanToggle;
    tick(1);
    checkOutput("tmo_release", busy, 0);

    $display("[TB] ack coincident with timeout");
    setWord(0, 32'hB0B00000);
    reqValid = 4'b0001;
    tick(1);
    checkOutput("coin_busy", busy, 1);
    reqValid = '0;
    tick(15);
    chanAckToggle = chanToggle;
    tick(1);
    checkOutput("coin_idle", busy, 0);
    checkOutput("coin_count", timeoutCount, 2);

    $display("[TB] reset mid transfer");
    setWord(3, 32'h33333333);
    reqValid = 4'b1000;
    tick(1);
    checkOutput("mid_busy", busy, 1);
    tick(2);
    applyStimulus(1'b1, 4'b1111, 1'b1);
    tick(1);
    checkOutput("mid_rstAck", reqAck, 0);
    checkOutput("mid_rstToggle", chanToggle, 0);
    checkOutput("mid_rstData", chanData, 0);
    checkOutput("mid_rstTag", chanTag, 0);
    checkOutput("mid_rstBusy", busy, 0);
    checkOutput("mid_rstCount", timeoutCount, 0);
    sysReset = 1'b0;
    tick(4);
    checkOutput("mid_noGrantBusy", busy, 0);
    checkOutput("mid_noGrantToggle", chanToggle, 0);
    chanAckToggle = 1'b0;
    tick(1);
    checkOutput("mid_firstTag", chanTag, 0);
    checkOutput("mid_firstAck", reqAck, 4'b0001);
    checkOutput("mid_firstBusy", busy, 1);

    reqValid = '0;
    chanAckToggle = chanToggle;
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
